// File: rtl/opb_s2p_pkg.sv
// rtl/opb_s2p_pkg.sv - register map, bit positions and bus FSM encoding for the simulink2ppc snap register
package opb_s2p_pkg;

   // Byte offsets within the slave window; the word index is bits [3:2].
   localparam logic [7:0] REG_DATA_OFS   = 8'h00;
   localparam logic [7:0] REG_CTRL_OFS   = 8'h04;
   localparam logic [7:0] REG_STATUS_OFS = 8'h08;
   localparam logic [7:0] REG_RSVD_OFS   = 8'h0C;

   localparam logic [1:0] WORD_DATA   = REG_DATA_OFS[3:2];
   localparam logic [1:0] WORD_CTRL   = REG_CTRL_OFS[3:2];
   localparam logic [1:0] WORD_STATUS = REG_STATUS_OFS[3:2];
   localparam logic [1:0] WORD_RSVD   = REG_RSVD_OFS[3:2];

   // Bit positions in OPB numbering (bit 0 is the MSB).
   localparam int CTRL_FREEZE_BIT = 31;
   localparam int STAT_NEW_BIT    = 0;
   localparam int STAT_CNT_MSB    = 16;
   localparam int STAT_CNT_LSB    = 31;
   localparam int CNT_W           = STAT_CNT_LSB - STAT_CNT_MSB + 1;
   localparam int FREEZE_BE_LANE  = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } bus_state_e;

   function automatic int opb_to_lsb(input int opb_bit, input int width);
      return width - 1 - opb_bit;
   endfunction

   // Internal vectors are [N-1:0]; these map OPB bit numbers onto them.
   localparam int FREEZE_IDX    = opb_to_lsb(CTRL_FREEZE_BIT, 32);
   localparam int NEW_IDX       = opb_to_lsb(STAT_NEW_BIT, 32);
   localparam int FREEZE_BE_IDX = opb_to_lsb(FREEZE_BE_LANE, 4);

endpackage

// File: rtl/opb_s2p_bus_if.sv
// rtl/opb_s2p_bus_if.sv - OPB address decode, IDLE/ACK handshake, read sampling and ack generation
module opb_s2p_bus_if
   import opb_s2p_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR = 32'h01003800,
   parameter logic [31:0] C_HIGHADDR = 32'h010038FF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] abus,
   input  logic        rnw,
   input  logic        select,
   input  logic [31:0] data_word,
   input  logic [31:0] ctrl_word,
   input  logic [31:0] status_word,
   output logic        xfer_start,
   output logic        xfer_rnw,
   output logic [1:0]  xfer_off,
   output logic [31:0] sl_dbus,
   output logic        sl_xfer_ack
);

   bus_state_e  state_q, state_d;
   logic        rnw_q, rnw_d;
   logic [31:0] rdata_q, rdata_d;
   logic        sel_hold_q, sel_hold_d;
   logic        hit;
   logic [1:0]  req_off;
   logic [31:0] mux_word;

   assign req_off = abus[3:2];
   assign hit     = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

   always_comb begin
      mux_word = '0;
      case (req_off)
         WORD_DATA:   mux_word = data_word;
         WORD_CTRL:   mux_word = ctrl_word;
         WORD_STATUS: mux_word = status_word;
         default:     mux_word = '0;
      endcase
   end

   // A master still holding select after its ack is in the same transfer;
   // it must drop select before it can be acknowledged again.
   always_comb begin
      state_d    = state_q;
      rnw_d      = rnw_q;
      rdata_d    = rdata_q;
      sel_hold_d = sel_hold_q && select;
      xfer_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hit && !sel_hold_q) begin
               state_d    = ST_ACK;
               rnw_d      = rnw;
               rdata_d    = rnw ? mux_word : '0;
               xfer_start = 1'b1;
            end
         end
         ST_ACK: begin
            state_d    = ST_IDLE;
            sel_hold_d = select;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rnw_q      <= 1'b0;
         rdata_q    <= '0;
         sel_hold_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rnw_q      <= rnw_d;
         rdata_q    <= rdata_d;
         sel_hold_q <= sel_hold_d;
      end
   end

   assign xfer_rnw    = rnw;
   assign xfer_off    = req_off;
   assign sl_xfer_ack = (state_q == ST_ACK);
   assign sl_dbus     = (sl_xfer_ack && rnw_q) ? rdata_q : '0;

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// rtl/opb_register_simulink2ppc_snap.sv - OPB slave publishing a fabric-captured 32-bit value to software
module opb_register_simulink2ppc_snap
   import opb_s2p_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h01003800,
   parameter logic [31:0] C_HIGHADDR   = 32'h010038FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter string       C_FAMILY     = "virtex5"
) (
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
   input  logic [0:3]              OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
   input  logic                    OPB_RNW,
   input  logic                    OPB_select,
   input  logic                    OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
   output logic                    Sl_errAck,
   output logic                    Sl_retry,
   output logic                    Sl_toutSup,
   output logic                    Sl_xferAck,
   input  logic [31:0]             user_data_in,
   input  logic                    user_data_valid,
   output logic                    user_frozen
);

   logic [31:0]      abus, wdata, rd_bus;
   logic [3:0]       be;
   logic [31:0]      data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             new_q, new_d;
   logic             freeze_q, freeze_d;
   logic             capture;
   logic [31:0]      ctrl_word, status_word;
   logic             xfer_start, xfer_rnw;
   logic [1:0]       xfer_off;
   logic             unused_ok;

   // Vector assignment keeps numeric value: OPB bit 0 lands on bit 31.
   assign abus      = OPB_ABus;
   assign wdata     = OPB_DBus;
   assign be        = OPB_BE;
   assign Sl_DBus   = rd_bus;
   assign unused_ok = ^{OPB_seqAddr, be[3:1], wdata[31:1]};

   always_comb begin
      ctrl_word             = '0;
      ctrl_word[FREEZE_IDX] = freeze_q;
      status_word           = '0;
      status_word[NEW_IDX]  = new_q;
      status_word[CNT_W-1:0] = cnt_q;
   end

   // Capture is gated by the freeze value already in the register, so a
   // freeze written on the same edge only blocks from the next edge.
   always_comb begin
      data_d   = data_q;
      cnt_d    = cnt_q;
      new_d    = new_q;
      freeze_d = freeze_q;
      capture  = user_data_valid && !freeze_q;
      if (xfer_start && !xfer_rnw && (xfer_off == WORD_CTRL) && be[FREEZE_BE_IDX])
         freeze_d = wdata[FREEZE_IDX];
      if (xfer_start && xfer_rnw && (xfer_off == WORD_DATA))
         new_d = 1'b0;
      if (capture) begin
         data_d = user_data_in;
         cnt_d  = cnt_q + 1'b1;
         new_d  = 1'b1;
      end
   end

   always_ff @(posedge OPB_Clk) begin
      if (!OPB_Rst) begin
         data_q   <= '0;
         cnt_q    <= '0;
         new_q    <= 1'b0;
         freeze_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         new_q    <= new_d;
         freeze_q <= freeze_d;
      end
   end

   opb_s2p_bus_if #(
      .C_BASEADDR (C_BASEADDR),
      .C_HIGHADDR (C_HIGHADDR)
   ) u_bus_if (
      .clk         (OPB_Clk),
      .rst_n       (OPB_Rst),
      .abus        (abus),
      .rnw         (OPB_RNW),
      .select      (OPB_select),
      .data_word   (data_q),
      .ctrl_word   (ctrl_word),
      .status_word (status_word),
      .xfer_start  (xfer_start),
      .xfer_rnw    (xfer_rnw),
      .xfer_off    (xfer_off),
      .sl_dbus     (rd_bus),
      .sl_xfer_ack (Sl_xferAck)
   );

   assign Sl_errAck   = 1'b0;
   assign Sl_retry    = 1'b0;
   assign Sl_toutSup  = 1'b0;
   assign user_frozen = freeze_q;

endmodule
